// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: single-entry valid/ready register
// carrying per-channel counts, saturation flags, winner index, any-spike flag
// and per-channel first-spike offsets.
//   master : decoder side (drives result, samples out_ready)
//   slave  : consumer side (samples result, drives out_ready)
interface spike_rate_decoder_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                            out_valid;
  logic                            out_ready;
  logic [NCH-1:0][CNT_W-1:0]       out_count;   // channel i at [i*CNT_W +: CNT_W]
  logic [NCH-1:0]                  out_sat;
  logic [IDX_W-1:0]                out_winner;
  logic                            out_any;
  logic [NCH-1:0][WIN_W-1:0]       out_first;

  modport master (
    output out_valid, out_count, out_sat, out_winner, out_any, out_first,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_count, out_sat, out_winner, out_any, out_first,
    output out_ready
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a window of enabled
// cycles and hands the result to a single-entry valid/ready register.
// Optional feature macro: SPIKE_LATENCY_EN (per-channel first-spike offset).
// Ports:
//   clk, rst       clock, async active-high reset
//   ena_i          sample enable (low pauses the window)
//   spike_in_i     NCH spike lines
//   start_i        begin a window (honoured in IDLE only)
//   continuous_i   auto-restart after each result load
//   window_len_i   window length in enabled cycles, 0 = 2^WIN_W
//   busy_o         high in COUNT or STALL
//   res_o          result channel (master modport)

// Per-channel counter. *_nxt_o is the value after this cycle's sample, which
// is what the result register captures on the last sample of a window.
module spike_rate_lane #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             sample_i,
  input  logic             spike_i,
`ifdef SPIKE_LATENCY_EN
  input  logic [WIN_W-1:0] idx_i,
  output logic [WIN_W-1:0] first_nxt_o,
`endif
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             sat_nxt_o
);
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  // sat flags a spike that arrived while the counter was already at max
  always_comb begin
    cnt_nxt_o = cnt_q;
    sat_nxt_o = sat_q;
    if (sample_i && spike_i) begin
      if (cnt_q == {CNT_W{1'b1}}) sat_nxt_o = 1'b1;
      else                        cnt_nxt_o = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt_o;
      sat_q <= sat_nxt_o;
    end
  end

`ifdef SPIKE_LATENCY_EN
  // separate seen bit so a first spike at index 2^WIN_W-1 is still recorded
  logic [WIN_W-1:0] first_q;
  logic             seen_q;
  logic             seen_nxt;

  always_comb begin
    first_nxt_o = first_q;
    seen_nxt    = seen_q;
    if (sample_i && spike_i && !seen_q) begin
      first_nxt_o = idx_i;
      seen_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr_i) begin
      first_q <= '1;
      seen_q  <= 1'b0;
    end else begin
      first_q <= first_nxt_o;
      seen_q  <= seen_nxt;
    end
  end
`endif
endmodule

module spike_rate_decoder #(
  parameter int NCH   = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_i,
  input  logic [NCH-1:0]     spike_in_i,
  input  logic               start_i,
  input  logic               continuous_i,
  input  logic [WIN_W-1:0]   window_len_i,
  output logic               busy_o,
  spike_rate_decoder_if.master res_o
);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_STALL} state_e;

  state_e                    state_q, state_d;
  logic [WIN_W:0]            rem_q, rem_d;   // one extra bit holds 2^WIN_W
  logic [WIN_W:0]            cap_len;
  logic                      sample, clr, load, accept, valid_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_nxt;
  logic [NCH-1:0]            sat_nxt;
  logic [IDX_W-1:0]          win;
  logic [CNT_W-1:0]          best;
  logic                      any;

  assign accept  = res_o.out_valid & res_o.out_ready;
  assign cap_len = (window_len_i == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len_i};
  assign busy_o  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clr     = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (ena_i) begin
          sample = 1'b1;
          if (rem_q == {{WIN_W{1'b0}}, 1'b1}) begin
            // result reg is free if empty or being drained this very cycle
            if (!res_o.out_valid || accept) load    = 1'b1;
            else                            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (accept) load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // clearing the counters on the load edge is safe: the result register
    // captures cnt_nxt, which already includes the final sample
    if (load) begin
      if (continuous_i) begin
        clr     = 1'b1;
        state_d = S_COUNT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    rem_d = rem_q;
    if (clr)         rem_d = cap_len;
    else if (sample) rem_d = rem_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SPIKE_LATENCY_EN
  logic [WIN_W-1:0]          idx_q;   // enabled-cycle index within window
  logic [NCH-1:0][WIN_W-1:0] first_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idx_q <= '0;
    else if (clr)    idx_q <= '0;
    else if (sample) idx_q <= idx_q + 1'b1;
  end
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    spike_rate_lane #(.CNT_W(CNT_W), .WIN_W(WIN_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .sample_i   (sample),
      .spike_i    (spike_in_i[g]),
`ifdef SPIKE_LATENCY_EN
      .idx_i      (idx_q),
      .first_nxt_o(first_nxt[g]),
`endif
      .cnt_nxt_o  (cnt_nxt[g]),
      .sat_nxt_o  (sat_nxt[g])
    );
  end

  // strict '>' keeps the lowest index on ties; all-zero leaves winner 0
  always_comb begin
    win  = '0;
    best = cnt_nxt[0];
    for (int i = 1; i < NCH; i++) begin
      if (cnt_nxt[i] > best) begin
        best = cnt_nxt[i];
        win  = IDX_W'(i);
      end
    end
    any = |cnt_nxt;
  end

  assign valid_d = load | (res_o.out_valid & ~res_o.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_o.out_valid  <= 1'b0;
      res_o.out_count  <= '0;
      res_o.out_sat    <= '0;
      res_o.out_winner <= '0;
      res_o.out_any    <= 1'b0;
    end else begin
      res_o.out_valid <= valid_d;
      if (load) begin
        res_o.out_count  <= cnt_nxt;
        res_o.out_sat    <= sat_nxt;
        res_o.out_winner <= win;
        res_o.out_any    <= any;
      end
    end
  end

`ifdef SPIKE_LATENCY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       res_o.out_first <= '0;
    else if (load) res_o.out_first <= first_nxt;
  end
`else
  assign res_o.out_first = '0;
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       ena, start, continuous;
  logic [7:0] spike_in, window_len;
  logic       busy;
  int         total = 0;
  int         bad   = 0;

  spike_rate_decoder_if #(.NCH(8), .CNT_W(8), .WIN_W(8)) rif ();

  spike_rate_decoder #(.NCH(8), .CNT_W(8), .WIN_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena_i       (ena),
    .spike_in_i  (spike_in),
    .start_i     (start),
    .continuous_i(continuous),
    .window_len_i(window_len),
    .busy_o      (busy),
    .res_o       (rif)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are checked at negedge, one posedge per cyc
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    rif.out_ready = 1'b1;
    cyc();
    rif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 0; start = 0; continuous = 0; spike_in = 0; window_len = 0;
    rif.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (rif.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", rif.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (rif.out_count !== 64'h0 || rif.out_winner !== 3'd0 || rif.out_any !== 1'b0 || rif.out_sat !== 8'h0)
      begin bad++; $display("FAIL rst_out cnt=%h win=%0d any=%0b sat=%h want 0", rif.out_count, rif.out_winner, rif.out_any, rif.out_sat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    window_len = 8'd4; start = 1'b1;
    cyc();
    start = 1'b0; ena = 1'b1; spike_in = 8'h01;
    for (int k = 0; k < 3; k++) cyc();
    total++; if (rif.out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_early valid=%0b busy=%0b want 0/1", rif.out_valid, busy); end
    cyc();
    total++; if (rif.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", rif.out_valid); end
    total++; if (rif.out_count !== 64'h04) begin bad++; $display("FAIL basic_count got=%h want=%h", rif.out_count, 64'h04); end
    total++; if (rif.out_winner !== 3'd0 || rif.out_any !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL basic_flags win=%0d any=%0b busy=%0b want 0/1/0", rif.out_winner, rif.out_any, busy); end
    spike_in = 8'h00; ena = 1'b0;
    drain();
    total++; if (rif.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0b want=0", rif.out_valid); end
  endtask

  task automatic test_ena_pause();
    window_len = 8'd6; start = 1'b1;
    cyc();
    start = 1'b0; spike_in = 8'hFF;
    for (int k = 1; k <= 10; k++) begin ena = k[0]; cyc(); end
    total++; if (rif.out_valid !== 1'b0) begin bad++; $display("FAIL pause_early got=%0b want=0", rif.out_valid); end
    ena = 1'b1; cyc();
    ena = 1'b0; spike_in = 8'h00;
    total++; if (rif.out_valid !== 1'b1 || rif.out_count !== {8{8'd6}})
      begin bad++; $display("FAIL pause_count valid=%0b cnt=%h want 1/%h", rif.out_valid, rif.out_count, {8{8'd6}}); end
    drain();
  endtask

  task automatic test_saturate();
    window_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0; ena = 1'b1; spike_in = 8'h08;
    for (int k = 0; k < 255; k++) cyc();
    total++; if (rif.out_valid !== 1'b0) begin bad++; $display("FAIL sat_early got=%0b want=0", rif.out_valid); end
    cyc();
    ena = 1'b0; spike_in = 8'h00;
    total++; if (rif.out_count !== 64'hFF00_0000 || rif.out_sat !== 8'h08 || rif.out_winner !== 3'd3)
      begin bad++; $display("FAIL sat_result cnt=%h sat=%h win=%0d want %h/08/3", rif.out_count, rif.out_sat, rif.out_winner, 64'hFF00_0000); end
    drain();
  endtask

  task automatic test_back_to_back();
    continuous = 1'b1; window_len = 8'd2; start = 1'b1; ena = 1'b1; spike_in = 8'h01;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    total++; if (rif.out_valid !== 1'b1 || rif.out_count !== 64'h02)
      begin bad++; $display("FAIL b2b_first valid=%0b cnt=%h want 1/02", rif.out_valid, rif.out_count); end
    spike_in = 8'h02;
    cyc(); cyc();
    spike_in = 8'h04;
    cyc(); cyc(); cyc();
    total++; if (rif.out_valid !== 1'b1 || rif.out_count !== 64'h02 || busy !== 1'b1)
      begin bad++; $display("FAIL b2b_hold valid=%0b cnt=%h busy=%0b want 1/02/1", rif.out_valid, rif.out_count, busy); end
    continuous = 1'b0; rif.out_ready = 1'b1;
    cyc();
    rif.out_ready = 1'b0; ena = 1'b0; spike_in = 8'h00;
    total++; if (rif.out_valid !== 1'b1 || rif.out_count !== 64'h0200 || rif.out_winner !== 3'd1)
      begin bad++; $display("FAIL b2b_second valid=%0b cnt=%h win=%0d want 1/0200/1", rif.out_valid, rif.out_count, rif.out_winner); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%0b want=0", busy); end
    drain();
  endtask

  task automatic test_ties_zero_reset();
    window_len = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0; ena = 1'b1; spike_in = 8'h24;
    cyc(); cyc(); cyc();
    total++; if (rif.out_count !== 64'h0000_0300_0003_0000 || rif.out_winner !== 3'd2)
      begin bad++; $display("FAIL tie cnt=%h win=%0d want %h/2", rif.out_count, rif.out_winner, 64'h0000_0300_0003_0000); end
    drain();
    window_len = 8'd2; start = 1'b1; spike_in = 8'h00;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    total++; if (rif.out_valid !== 1'b1 || rif.out_winner !== 3'd0 || rif.out_any !== 1'b0 || rif.out_count !== 64'h0)
      begin bad++; $display("FAIL zero valid=%0b win=%0d any=%0b cnt=%h want 1/0/0/0", rif.out_valid, rif.out_winner, rif.out_any, rif.out_count); end
    // leave that result pending, start another window, reset mid-COUNT
    window_len = 8'd10; start = 1'b1;
    cyc();
    start = 1'b0; spike_in = 8'hFF;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    #1;
    total++; if (rif.out_valid !== 1'b0 || busy !== 1'b0 || rif.out_count !== 64'h0)
      begin bad++; $display("FAIL midrst valid=%0b busy=%0b cnt=%h want 0/0/0", rif.out_valid, busy, rif.out_count); end
    @(negedge clk);
    rst = 1'b0; ena = 1'b0; spike_in = 8'h00;
    cyc();
  endtask

  task automatic test_latency();
    logic [7:0] exp_first [8];
    window_len = 8'd6; start = 1'b1;
    cyc();
    start = 1'b0;
    ena = 1; spike_in = 8'h01; cyc();   // idx 0
    ena = 1; spike_in = 8'h00; cyc();   // idx 1
    ena = 0; spike_in = 8'hFF; cyc();   // paused, ignored
    ena = 1; spike_in = 8'h00; cyc();   // idx 2
    ena = 1; spike_in = 8'h02; cyc();   // idx 3
    ena = 1; spike_in = 8'h03; cyc();   // idx 4
    ena = 1; spike_in = 8'h00; cyc();   // idx 5
    ena = 0;
`ifdef SPIKE_LATENCY_EN
    for (int i = 0; i < 8; i++) exp_first[i] = 8'hFF;
    exp_first[0] = 8'd0;
    exp_first[1] = 8'd3;
`else
    for (int i = 0; i < 8; i++) exp_first[i] = 8'h00;
`endif
    total++; if (rif.out_valid !== 1'b1 || rif.out_count !== 64'h0202 || rif.out_winner !== 3'd0)
      begin bad++; $display("FAIL lat_count valid=%0b cnt=%h win=%0d want 1/0202/0", rif.out_valid, rif.out_count, rif.out_winner); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rif.out_first[i] !== exp_first[i])
        begin bad++; $display("FAIL lat_first[%0d] got=%h want=%h", i, rif.out_first[i], exp_first[i]); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ena_pause();
    test_saturate();
    test_back_to_back();
    test_ties_zero_reset();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
